mc_wdata_drain: RTL and testbench

Write-data drain engine for the memory controller's write path. Sits on the pop side of the write-data synchronous FIFO and turns a write-burst request into exactly BL beats on the write-data output, aligned to a programmable write latency. FIFO underrun mid-burst is recorded, never stalls the burst: DRAM write timing cannot slip, so the missing beat is zeroed and masked.

---
 rtl/mc_wdata_drain.sv | 150 +++++++++++++++
 tb/tb_mc_wdata_drain.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mc_wdata_drain.sv
// Write-data drain: pops BL beats from the write-data FIFO after a programmable latency.
// Optional MC_WDATA_PARITY_EN adds a registered even-parity bit on the write-data beat.
module mc_wdata_drain #(
    parameter int WIDTH  = 8,
    parameter int BL     = 8,
    parameter int WL_MAX = 15,
    localparam int LAT_W  = $clog2(WL_MAX + 1),
    localparam int BEAT_W = $clog2(BL)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_start_i,
    input  logic [LAT_W-1:0] wr_lat_i,
    output logic             wr_busy_o,
    output logic             pop_o,
    input  logic [WIDTH-1:0] pop_data_i,
    input  logic             pop_vld_i,
    output logic             wrdata_en_o,
    output logic [WIDTH-1:0] wrdata_o,
    output logic             wrdata_mask_o,
    output logic             done_o,
    output logic             underrun_o,
    input  logic             underrun_clr_i
`ifdef MC_WDATA_PARITY_EN
    ,
    output logic             wrdata_par_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
    logic [BEAT_W-1:0]  beat_cnt_reg, beat_cnt_next;

    logic               wrdata_en_reg, wrdata_en_next;
    logic [WIDTH-1:0]   wrdata_reg, wrdata_next;
    logic               wrdata_mask_reg, wrdata_mask_next;
    logic               done_reg, done_next;
    logic               underrun_reg, underrun_next;

    logic               in_burst;
    logic               last_beat;

    assign in_burst  = (state_reg == BURST);
    assign last_beat = (beat_cnt_reg == BEAT_W'(BL - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg       <= IDLE;
            lat_cnt_reg     <= '0;
            beat_cnt_reg    <= '0;
            wrdata_en_reg   <= 1'b0;
            wrdata_reg      <= '0;
            wrdata_mask_reg <= 1'b0;
            done_reg        <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lat_cnt_reg     <= lat_cnt_next;
            beat_cnt_reg    <= beat_cnt_next;
            wrdata_en_reg   <= wrdata_en_next;
            wrdata_reg      <= wrdata_next;
            wrdata_mask_reg <= wrdata_mask_next;
            done_reg        <= done_next;
            underrun_reg    <= underrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lat_cnt_next  = lat_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                beat_cnt_next = '0;
                if (wr_start_i) begin
                    if (wr_lat_i == '0) begin
                        state_next = BURST;
                    end else begin
                        lat_cnt_next = wr_lat_i;
                        state_next   = WAIT;
                    end
                end
            end
            WAIT: begin
                // Terminal count is 1 so WAIT spans exactly wr_lat cycles.
                lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                if (lat_cnt_reg == LAT_W'(1)) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    beat_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                lat_cnt_next  = '0;
                beat_cnt_next = '0;
            end
        endcase
    end

    // Underrun never stalls: the slot is spent on a zeroed, masked beat.
    always_comb begin
        wrdata_en_next   = in_burst;
        wrdata_next      = (in_burst && pop_vld_i) ? pop_data_i : '0;
        wrdata_mask_next = in_burst && !pop_vld_i;
        done_next        = in_burst && last_beat;
        underrun_next    = underrun_reg;
        if (wrdata_mask_next) begin
            underrun_next = 1'b1;
        end else if (underrun_clr_i) begin
            underrun_next = 1'b0;
        end
    end

    assign wr_busy_o     = (state_reg != IDLE);
    assign pop_o         = in_burst;
    assign wrdata_en_o   = wrdata_en_reg;
    assign wrdata_o      = wrdata_reg;
    assign wrdata_mask_o = wrdata_mask_reg;
    assign done_o        = done_reg;
    assign underrun_o    = underrun_reg;

`ifdef MC_WDATA_PARITY_EN
    logic wrdata_par_reg;

    // Masked beats carry zero data, so their parity is naturally 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrdata_par_reg <= 1'b0;
        end else begin
            wrdata_par_reg <= ^wrdata_next;
        end
    end

    assign wrdata_par_o = wrdata_par_reg;
`endif

endmodule

// File: tb/tb_mc_wdata_drain.sv
// Directed bench for mc_wdata_drain with a small behavioural write-data FIFO.
// Build with MC_WDATA_PARITY_EN to also check the parity output.
module tb_mc_wdata_drain;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       wr_start_i = 1'b0;
    logic [3:0] wr_lat_i = 4'd0;
    logic       wr_busy_o;
    logic       pop_o;
    logic [7:0] pop_data_i;
    logic       pop_vld_i;
    logic       wrdata_en_o;
    logic [7:0] wrdata_o;
    logic       wrdata_mask_o;
    logic       done_o;
    logic       underrun_o;
    logic       underrun_clr_i = 1'b0;
`ifdef MC_WDATA_PARITY_EN
    logic       wrdata_par_o;
`endif

    int errors = 0;
    int checks = 0;
    logic urun_model = 1'b0;

    always #5 clk_i = ~clk_i;

    mc_wdata_drain #(.WIDTH(8), .BL(8), .WL_MAX(15)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .wr_start_i    (wr_start_i),
        .wr_lat_i      (wr_lat_i),
        .wr_busy_o     (wr_busy_o),
        .pop_o         (pop_o),
        .pop_data_i    (pop_data_i),
        .pop_vld_i     (pop_vld_i),
        .wrdata_en_o   (wrdata_en_o),
        .wrdata_o      (wrdata_o),
        .wrdata_mask_o (wrdata_mask_o),
        .done_o        (done_o),
        .underrun_o    (underrun_o),
        .underrun_clr_i(underrun_clr_i)
`ifdef MC_WDATA_PARITY_EN
        ,
        .wrdata_par_o  (wrdata_par_o)
`endif
    );

    // Behavioural FIFO: combinational head, pop on the clock edge.
    logic [7:0] fifo_mem [0:31];
    logic [4:0] rd_ptr = 5'd0;
    logic [4:0] wr_ptr = 5'd0;
    logic       fifo_clr = 1'b0;

    assign pop_data_i = fifo_mem[rd_ptr];
    assign pop_vld_i  = pop_o && (rd_ptr != wr_ptr);

    always @(posedge clk_i) begin
        if (fifo_clr) rd_ptr <= 5'd0;
        else if (pop_vld_i) rd_ptr <= rd_ptr + 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load(input logic [7:0] base, input int n);
        fifo_clr = 1'b1;
        wr_ptr   = 5'd0;
        @(posedge clk_i); #1;
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) fifo_mem[i] = base + 8'(i);
        wr_ptr = 5'(n);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(wr_busy_o), 32'd0);
        chk({tag, "_pop"}, 32'(pop_o), 32'd0);
        chk({tag, "_en"}, 32'(wrdata_en_o), 32'd0);
        chk({tag, "_data"}, 32'(wrdata_o), 32'd0);
        chk({tag, "_mask"}, 32'(wrdata_mask_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_urun"}, 32'(underrun_o), 32'd0);
`ifdef MC_WDATA_PARITY_EN
        chk({tag, "_par"}, 32'(wrdata_par_o), 32'd0);
`endif
    endtask

    // Issues a request in the current cycle T, then checks cycles T+1..T+lat+9
    // (or up to stop_k). Returns at the negedge of the last checked cycle.
    task automatic burst(input int lat, input int nvalid, input logic [7:0] base,
                         input int poke_k, input int stop_k);
        logic       busy_e, pop_e, en_e, mask_e, done_e;
        logic [7:0] data_e;
        int         beat;
        wr_lat_i   = 4'(lat);
        wr_start_i = 1'b1;
        @(posedge clk_i); #1;
        wr_start_i = 1'b0;
        for (int k = 1; k <= lat + 9 && k <= stop_k; k++) begin
            @(negedge clk_i);
            busy_e = (k <= lat + 8);
            pop_e  = (k >= lat + 1) && (k <= lat + 8);
            en_e   = (k >= lat + 2) && (k <= lat + 9);
            beat   = k - lat - 2;
            mask_e = en_e && (beat >= nvalid);
            data_e = (en_e && !mask_e) ? base + 8'(beat) : 8'h00;
            done_e = (k == lat + 9);
            if (mask_e) urun_model = 1'b1;
            chk($sformatf("busy_k%0d", k), 32'(wr_busy_o), 32'(busy_e));
            chk($sformatf("pop_k%0d", k), 32'(pop_o), 32'(pop_e));
            chk($sformatf("en_k%0d", k), 32'(wrdata_en_o), 32'(en_e));
            chk($sformatf("data_k%0d", k), 32'(wrdata_o), 32'(data_e));
            chk($sformatf("mask_k%0d", k), 32'(wrdata_mask_o), 32'(mask_e));
            chk($sformatf("done_k%0d", k), 32'(done_o), 32'(done_e));
            chk($sformatf("urun_k%0d", k), 32'(underrun_o), 32'(urun_model));
`ifdef MC_WDATA_PARITY_EN
            chk($sformatf("par_k%0d", k), 32'(wrdata_par_o), 32'(^data_e));
`endif
            wr_start_i = (k == poke_k);
        end
        wr_start_i = 1'b0;
        $display("burst lat=%0d valid=%0d base=%0h done", lat, nvalid, base);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("post_reset");

        // wr_lat=0, full FIFO 0x10..0x17
        load(8'h10, 8);
        burst(0, 8, 8'h10, 0, 99);

        // wr_lat=3, pop_o held low during WAIT
        load(8'h20, 8);
        burst(3, 8, 8'h20, 0, 99);

        // Underrun: only 5 beats available
        load(8'h30, 5);
        burst(0, 5, 8'h30, 0, 99);
        @(negedge clk_i);
        chk("urun_sticky", 32'(underrun_o), 32'd1);
        underrun_clr_i = 1'b1;
        @(negedge clk_i);
        underrun_clr_i = 1'b0;
        urun_model = 1'b0;
        chk("urun_cleared", 32'(underrun_o), 32'd0);
        $display("underrun clear checked");

        // Mid-burst request ignored, then back-to-back request in the done cycle
        load(8'h10, 16);
        burst(0, 8, 8'h10, 4, 99);
        burst(2, 8, 8'h18, 0, 99);
        @(negedge clk_i);
        chk("no_queue_busy", 32'(wr_busy_o), 32'd0);

        // Reset in beat 4 aborts immediately
        load(8'h10, 8);
        burst(0, 8, 8'h10, 0, 4);
        rst_n_i = 1'b0;
        #1;
        urun_model = 1'b0;
        check_idle_outputs("abort");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("after_abort");
        $display("mid-burst reset checked");

        load(8'h10, 8);
        burst(0, 8, 8'h10, 0, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
